// File: rtl/i2s_audio_tx.sv
// i2s_audio_tx: serialises 16-bit signed stereo PCM to I2S on the single clk32 domain.
// The bit clock comes from a fractional NCO: two ticks per BCK period and 64 BCK per frame.
// Each frame has two 32-bit slots.
// Build option: define I2S_LEFT_JUSTIFIED_EN for left-justified framing. In that format the
// MSB coincides with the LRCK change. Otherwise the standard I2S one-BCK delay is used.
module i2s_audio_tx #(
   parameter int unsigned CLK_RATE    = 32000000,
   parameter int unsigned SAMPLE_RATE = 48000
) (
   input  logic        clk32,
   input  logic        reset_n,
   input  logic [15:0] left_in,
   input  logic [15:0] right_in,
   input  logic        sample_valid,
   input  logic        mute,
   output logic        sample_req,
   output logic        I2S_BCK,
   output logic        I2S_LRCK,
   output logic        I2S_DATA
);

   // Two NCO ticks per bit, 64 bits per frame.
   localparam logic [32:0] IncW = 33'(64'(SAMPLE_RATE) * 64'd128);
   localparam logic [32:0] ClkW = 33'(CLK_RATE);

   if (64'(SAMPLE_RATE) * 64'd128 >= 64'(CLK_RATE)) begin : gen_rate_check
      $error("i2s_audio_tx: 128*SAMPLE_RATE must be below CLK_RATE");
   end

   logic [31:0] acc_q, acc_d;
   logic        bck_q, bck_d;
   logic        lrck_q, lrck_d;
   logic        data_q, data_d;
   logic [5:0]  bit_cnt_q, bit_cnt_d;
   logic [15:0] hold_l_q, hold_l_d, hold_r_q, hold_r_d;
   logic [15:0] shift_l_q, shift_l_d, shift_r_q, shift_r_d;

   logic [32:0] acc_sum;
   logic        tick, fall, frame_load;
   logic [5:0]  cnt_nxt;
   logic [15:0] load_l, load_r;

   // NCO, bit counter, slot map and sample handshake.
   always_comb begin
      acc_sum    = {1'b0, acc_q} + IncW;
      tick       = (acc_sum >= ClkW);
      acc_d      = tick ? 32'(acc_sum - ClkW) : acc_sum[31:0];
      fall       = tick & bck_q;
      cnt_nxt    = bit_cnt_q + 6'd1;
      frame_load = fall & (cnt_nxt == 6'd0);
      // A strobe in the load clk bypasses the holding regs straight into the shifter.
      load_l     = mute ? 16'h0000 : (sample_valid ? left_in : hold_l_q);
      load_r     = mute ? 16'h0000 : (sample_valid ? right_in : hold_r_q);

      bck_d      = bck_q;
      lrck_d     = lrck_q;
      data_d     = data_q;
      bit_cnt_d  = bit_cnt_q;
      hold_l_d   = hold_l_q;
      hold_r_d   = hold_r_q;
      shift_l_d  = shift_l_q;
      shift_r_d  = shift_r_q;

      if (sample_valid) begin
         hold_l_d = left_in;
         hold_r_d = right_in;
      end
      if (tick) begin
         bck_d = ~bck_q;
      end
      // LRCK and DATA move only on BCK falling edges.
      if (fall) begin
         bit_cnt_d = cnt_nxt;
         lrck_d    = cnt_nxt[5];
         data_d    = 1'b0;
         if (frame_load) begin
            shift_l_d = load_l;
            shift_r_d = load_r;
         end
`ifdef I2S_LEFT_JUSTIFIED_EN
         if (frame_load) begin
            data_d    = load_l[15];
            shift_l_d = {load_l[14:0], 1'b0};
         end else if (cnt_nxt < 6'd16) begin
            data_d    = shift_l_q[15];
            shift_l_d = {shift_l_q[14:0], 1'b0};
         end else if (cnt_nxt >= 6'd32 && cnt_nxt < 6'd48) begin
            data_d    = shift_r_q[15];
            shift_r_d = {shift_r_q[14:0], 1'b0};
         end
`else
         if (cnt_nxt >= 6'd1 && cnt_nxt <= 6'd16) begin
            data_d    = shift_l_q[15];
            shift_l_d = {shift_l_q[14:0], 1'b0};
         end else if (cnt_nxt >= 6'd33 && cnt_nxt <= 6'd48) begin
            data_d    = shift_r_q[15];
            shift_r_d = {shift_r_q[14:0], 1'b0};
         end
`endif
      end
   end

   // State registers; bit_cnt resets to 63 so the first falling edge opens a fresh frame.
   always_ff @(posedge clk32 or negedge reset_n) begin
      if (!reset_n) begin
         acc_q     <= '0;
         bck_q     <= 1'b0;
         lrck_q    <= 1'b0;
         data_q    <= 1'b0;
         bit_cnt_q <= 6'd63;
         hold_l_q  <= '0;
         hold_r_q  <= '0;
         shift_l_q <= '0;
         shift_r_q <= '0;
      end else begin
         acc_q     <= acc_d;
         bck_q     <= bck_d;
         lrck_q    <= lrck_d;
         data_q    <= data_d;
         bit_cnt_q <= bit_cnt_d;
         hold_l_q  <= hold_l_d;
         hold_r_q  <= hold_r_d;
         shift_l_q <= shift_l_d;
         shift_r_q <= shift_r_d;
      end
   end

   assign sample_req = frame_load;
   assign I2S_BCK    = bck_q;
   assign I2S_LRCK   = lrck_q;
   assign I2S_DATA   = data_q;

endmodule

// File: tb/tb_i2s_audio_tx.sv
// tb_i2s_audio_tx: frame receiver with a scoreboard of expected frames, plus timing checks.
`timescale 1ns/1ps
module tb_i2s_audio_tx;

   logic        clk32 = 1'b0;
   logic        reset_n = 1'b0;
   logic [15:0] left_in = '0;
   logic [15:0] right_in = '0;
   logic        sample_valid = 1'b0;
   logic        mute = 1'b0;
   logic        sample_req, I2S_BCK, I2S_LRCK, I2S_DATA;

   int unsigned n_checks = 0;
   int unsigned n_fail = 0;
   int unsigned n_pushed = 0;
   int unsigned n_framechk = 0;
   logic [31:0] exp_q[$];

`ifdef I2S_LEFT_JUSTIFIED_EN
   localparam logic [15:0] DataL = 16'hC003;
`else
   localparam logic [15:0] DataL = 16'h8001;
`endif

   always #5 clk32 = ~clk32;

   i2s_audio_tx dut (
      .clk32        (clk32),
      .reset_n      (reset_n),
      .left_in      (left_in),
      .right_in     (right_in),
      .sample_valid (sample_valid),
      .mute         (mute),
      .sample_req   (sample_req),
      .I2S_BCK      (I2S_BCK),
      .I2S_LRCK     (I2S_LRCK),
      .I2S_DATA     (I2S_DATA)
   );

   // Expected 64-bit frame, slot 0 at bit 63.
   function automatic logic [63:0] make_frame(input logic [31:0] lr);
      logic [63:0] f;
      f = '0;
`ifdef I2S_LEFT_JUSTIFIED_EN
      f[63:48] = lr[31:16];
      f[31:16] = lr[15:0];
`else
      f[62:47] = lr[31:16];
      f[30:15] = lr[15:0];
`endif
      return f;
   endfunction

   logic        mon_prev_bck = 1'b0;
   logic        mon_on = 1'b0;
   logic        mon_pend = 1'b0;
   logic        mon_exp_ok = 1'b0;
   int unsigned mon_idx = 0;
   logic [31:0] mon_exp = '0;
   logic [63:0] mon_data = '0;
   logic [63:0] mon_lr = '0;

   // I2S receiver: samples on BCK rise; frame starts after sample_req; compares against scoreboard.
   always @(negedge clk32) begin
      if (!reset_n) begin
         mon_on = 1'b0;
         mon_pend = 1'b0;
         mon_exp_ok = 1'b0;
         mon_prev_bck = 1'b0;
      end else begin
         if (mon_pend) begin
            mon_pend = 1'b0;
            mon_exp_ok = (exp_q.size() != 0);
            if (mon_exp_ok) mon_exp = exp_q.pop_front();
         end
         if (sample_req) begin
            mon_on = 1'b1;
            mon_idx = 0;
            mon_pend = 1'b1;
            mon_exp_ok = 1'b0;
         end
         if (I2S_BCK && !mon_prev_bck && mon_on && mon_idx < 64) begin
            mon_data = {mon_data[62:0], I2S_DATA};
            mon_lr = {mon_lr[62:0], I2S_LRCK};
            mon_idx++;
            if (mon_idx == 64 && mon_exp_ok) begin
               n_framechk++;
               n_checks++;
               if (mon_data !== make_frame(mon_exp)) begin
                  n_fail++;
                  $display("FAIL frame_data: got %h expected %h", mon_data, make_frame(mon_exp));
               end
               n_checks++;
               if (mon_lr !== 64'h00000000_FFFFFFFF) begin
                  n_fail++;
                  $display("FAIL frame_lrck: got %h expected %h", mon_lr,
                           64'h00000000_FFFFFFFF);
               end
               mon_exp_ok = 1'b0;
            end
         end
         mon_prev_bck = I2S_BCK;
      end
   end

   // Advances to the next sample_req clk (observed at negedge), bounded.
   task automatic wait_req(input string tag);
      int unsigned n;
      n = 0;
      do begin
         @(negedge clk32);
         n++;
      end while (!sample_req && n < 2000);
      if (!sample_req) begin
         n_checks++;
         n_fail++;
         $display("FAIL %s: got no sample_req, expected one within 2000 clk", tag);
      end
   endtask

   task automatic test_reset();
      reset_n = 1'b0;
      repeat (3) @(negedge clk32);
      n_checks++;
      if (I2S_BCK !== 1'b0) begin n_fail++; $display("FAIL rst_bck: got %b expected 0", I2S_BCK); end
      n_checks++;
      if (I2S_LRCK !== 1'b0) begin n_fail++; $display("FAIL rst_lrck: got %b expected 0", I2S_LRCK); end
      n_checks++;
      if (I2S_DATA !== 1'b0) begin n_fail++; $display("FAIL rst_data: got %b expected 0", I2S_DATA); end
      n_checks++;
      if (sample_req !== 1'b0) begin n_fail++; $display("FAIL rst_req: got %b expected 0", sample_req); end
      reset_n = 1'b1;
   endtask

   task automatic test_rate();
      int unsigned cyc, t_first, t_last, nrise, falls;
      logic        plr, pb;
      cyc = 0; t_first = 0; t_last = 0; nrise = 0; falls = 0;
      plr = I2S_LRCK;
      pb = I2S_BCK;
      while (nrise <= 30 && cyc < 30000) begin
         @(negedge clk32);
         cyc++;
         if (pb && !I2S_BCK) falls++;
         if (I2S_LRCK && !plr) begin
            if (nrise != 0) begin
               n_checks++;
               if (cyc - t_last != 666 && cyc - t_last != 667) begin
                  n_fail++;
                  $display("FAIL rate_period: got %0d clk expected 666 or 667", cyc - t_last);
               end
               n_checks++;
               if (falls != 64) begin
                  n_fail++;
                  $display("FAIL rate_falls: got %0d expected 64", falls);
               end
            end else begin
               t_first = cyc;
            end
            t_last = cyc;
            falls = 0;
            nrise++;
         end
         plr = I2S_LRCK;
         pb = I2S_BCK;
      end
      n_checks++;
      if (nrise <= 30) begin
         n_fail++;
         $display("FAIL rate_timeout: got %0d LRCK rises expected 31", nrise);
      end else if (t_last - t_first < 19999 || t_last - t_first > 20001) begin
         n_fail++;
         $display("FAIL rate_total: got %0d clk expected 20000 +/-1", t_last - t_first);
      end
   endtask

   task automatic test_data();
      wait_req("data_sync");
      repeat (20) @(negedge clk32);
      left_in = DataL;
      right_in = 16'h7FFE;
      sample_valid = 1'b1;
      @(negedge clk32);
      sample_valid = 1'b0;
      left_in = '0;
      right_in = '0;
      wait_req("data_load");
      exp_q.push_back({DataL, 16'h7FFE});
      n_pushed++;
      wait_req("data_done");
   endtask

   task automatic test_hold();
      repeat (20) @(negedge clk32);
      left_in = 16'h1234;
      right_in = 16'hABCD;
      sample_valid = 1'b1;
      @(negedge clk32);
      sample_valid = 1'b0;
      left_in = '0;
      right_in = '0;
      for (int i = 0; i < 10; i++) begin
         wait_req("hold_load");
         exp_q.push_back({16'h1234, 16'hABCD});
         n_pushed++;
      end
      wait_req("hold_done");
   endtask

   task automatic test_bypass();
      wait_req("byp_load");
      left_in = 16'h00FF;
      right_in = 16'hF00F;
      sample_valid = 1'b1;
      exp_q.push_back({16'h00FF, 16'hF00F});
      n_pushed++;
      @(negedge clk32);
      sample_valid = 1'b0;
      left_in = '0;
      right_in = '0;
      wait_req("byp_hold");
      exp_q.push_back({16'h00FF, 16'hF00F});
      n_pushed++;
      wait_req("byp_done");
   endtask

   task automatic test_mute();
      repeat (20) @(negedge clk32);
      mute = 1'b1;
      wait_req("mute_load");
      exp_q.push_back(32'h0);
      n_pushed++;
      @(negedge clk32);
      mute = 1'b0;
      wait_req("unmute_load");
      exp_q.push_back({16'h00FF, 16'hF00F});
      n_pushed++;
      wait_req("mute_done");
   endtask

   task automatic test_reset_mid();
      int unsigned n, rises;
      logic        pb;
      wait_req("rst_sync");
      n = 0;
      while (!(I2S_LRCK && I2S_DATA) && n < 1000) begin
         @(negedge clk32);
         n++;
      end
      n_checks++;
      if (!(I2S_LRCK && I2S_DATA)) begin
         n_fail++;
         $display("FAIL rst_mid_setup: got LRCK=%b DATA=%b expected both 1", I2S_LRCK, I2S_DATA);
      end
      #2 reset_n = 1'b0;
      #1;
      n_checks++;
      if ({I2S_BCK, I2S_LRCK, I2S_DATA, sample_req} !== 4'b0000) begin
         n_fail++;
         $display("FAIL rst_mid_async: got %b expected 0000",
                  {I2S_BCK, I2S_LRCK, I2S_DATA, sample_req});
      end
      repeat (3) @(negedge clk32);
      reset_n = 1'b1;
      rises = 0;
      n = 0;
      pb = I2S_BCK;
      do begin
         @(negedge clk32);
         n++;
         if (I2S_BCK && !pb) rises++;
         pb = I2S_BCK;
      end while (!sample_req && n < 100);
      n_checks++;
      if (!sample_req || rises != 1) begin
         n_fail++;
         $display("FAIL rst_restart: got req=%b rises=%0d expected req=1 rises=1", sample_req, rises);
      end
      // Holding regs were cleared by reset.
      exp_q.push_back(32'h0);
      n_pushed++;
      wait_req("rst_done");
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got timeout expected test completion");
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_rate();
      test_data();
      test_hold();
      test_bypass();
      test_mute();
      test_reset_mid();
      n_checks++;
      if (exp_q.size() != 0 || n_framechk != n_pushed) begin
         n_fail++;
         $display("FAIL scoreboard: got %0d frames checked %0d left expected %0d checked 0 left",
                  n_framechk, exp_q.size(), n_pushed);
      end
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
